// File: rtl/alu_logic_pkg.sv
// rtl/alu_logic_pkg.sv - shared op encodings, FSM states and slice width
package alu_logic_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_serializer_32_if.sv
// rtl/logic_serializer_32_if.sv - operation/result handshake bundle
interface logic_serializer_32_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, num1, num2, op, out_ready,
    input  in_ready, out_valid, out, zero, busy
  );

  modport slave (
    input  in_valid, num1, num2, op, out_ready,
    output in_ready, out_valid, out, zero, busy
  );

endinterface

// File: rtl/logic_slice_8.sv
// rtl/logic_slice_8.sv - combinational bitwise unit for one byte slice
module logic_slice_8
  import alu_logic_pkg::*;
#(
  parameter int W = SLICE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_serializer_32.sv
// rtl/logic_serializer_32.sv - bitwise logic unit processing one byte slice per cycle
module logic_serializer_32
  import alu_logic_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = alu_logic_pkg::SLICE_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  logic_serializer_32_if.slave   bus
);

  localparam int NSL = WIDTH / SLICE_W;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  state_e             state;
  state_e             state_n;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  op_e                op_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_n;
  logic [WIDTH-1:0]   out_q;
  logic               zero_q;
  logic [IW-1:0]      idx;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] y_sl;
  logic               last;

  assign a_sl = a_q[idx*SLICE_W +: SLICE_W];
  assign b_sl = b_q[idx*SLICE_W +: SLICE_W];
  assign last = (idx == IW'(NSL - 1));

  logic_slice_8 #(.W(SLICE_W)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .op (op_q),
    .y  (y_sl)
  );

  // Working result is kept apart from out so out only changes when a full result lands
  always_comb begin
    res_n = res_q;
    res_n[idx*SLICE_W +: SLICE_W] = y_sl;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_n = RUN;
      RUN:     if (last)          state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
      res_q  <= '0;
      out_q  <= '0;
      zero_q <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q  <= bus.num1;
            b_q  <= bus.num2;
            op_q <= op_e'(bus.op);
            idx  <= '0;
          end
        end
        RUN: begin
          res_q <= res_n;
          idx   <= idx + 1'b1;
          if (last) begin
            out_q  <= res_n;
            zero_q <= (res_n == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by reset_n so it reads 0 for the whole reset pulse
  assign bus.in_ready  = reset_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;

endmodule

// File: doc/logic_serializer_32.md
LOGIC_SERIALIZER_32 -- requirements
Module: logic_serializer_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width; it must be a multiple of 8.
REQ-002 SHALL have parameter SLICE_W, default 8, giving the byte-slice width processed per cycle.
REQ-003 SHALL have port clock  input  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers an operation.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port num1  input  WIDTH  operand A.
REQ-008 SHALL have port num2  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  downstream takes the result.
REQ-012 SHALL have port out  output  WIDTH  result.
REQ-013 SHALL have port zero  output  1  result equals 0.
REQ-014 SHALL have port busy  output  1  high while the state is not IDLE.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-016 In IDLE, SHALL drive in_ready=1; on an edge with in_valid=1, SHALL capture num1, num2 and op, clear the slice index to 0 and go to RUN.
REQ-017 In RUN, SHALL compute one SLICE_W slice per cycle, selected by the index (bits [8i+7:8i]), write it into result byte i, and increment i.
REQ-018 On the edge that writes slice WIDTH/SLICE_W-1, SHALL go to DONE and register zero = (full result == 0).
REQ-019 Latency: out_valid SHALL rise after the 4th edge following the acceptance edge (WIDTH=32).
REQ-020 In DONE, SHALL drive out_valid=1 and hold out and zero stable until an edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-021 in_ready SHALL be 1 only in IDLE; in_valid in RUN or DONE SHALL be ignored.
REQ-022 Changes on num1, num2 or op after acceptance SHALL NOT affect the result.
REQ-023 out SHALL keep its last value in IDLE and RUN; out_valid SHALL qualify it.
REQ-024 Minimum issue period SHALL be 6 cycles: accept, 4×RUN, DONE with out_ready=1.

Reset
REQ-025 Asserting reset_n=0 SHALL immediately force the following values at any time, including mid-RUN: state=IDLE, out=0, zero=0, out_valid=0, busy=0 and slice index=0.
REQ-026 SHALL drive in_ready=0 while reset_n=0 and in_ready=1 from the first cycle after deassertion.

Structure
REQ-027 Shared package alu_logic_pkg SHALL hold the op encodings, the FSM state typedef and SLICE_W.
REQ-028 SHALL instantiate exactly one sub-module, logic_slice_8, as the combinational byte unit computing AND/OR/XOR/NOR, reused every RUN cycle.
REQ-029 All state SHALL be in a single clock domain, with no latches.

Verification
REQ-030 SHALL verify: num1=0x0F0F00FF, num2=0xF0000F00, op=01 -> out=0xFF0F0FFF, zero=0, with out_valid after 4 edges post-accept.
REQ-031 SHALL verify: num1=0xAAAAAAAA, num2=0x55555555, op=00 -> out=0x00000000, zero=1.
REQ-032 SHALL verify: op=11 with both operands 0, and num1 changed to 0xFFFFFFFF the cycle after acceptance -> out=0xFFFFFFFF.
REQ-033 SHALL verify: out_ready=0 held for 10 cycles in DONE -> out_valid=1, out stable and in_ready=0 throughout; out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-034 SHALL verify: reset_n pulsed low after 2 RUN cycles -> out=0, out_valid=0 and busy=0 immediately; a new op=10 (0x12345678 ^ 0xFFFFFFFF) then yields 0xEDCBA987.
REQ-035 SHALL verify: in_valid held high with two queued ops and out_ready=1 -> the second op is accepted exactly 6 edges after the first.
